// File: rtl/l2_per_apb_bridge.sv
// Purpose : bridges single-beat PER requests from the L2 demux onto N_PERIPHS APB slaves chosen by address range.
// Latency : grant -> SETUP +1, ACCESS +2, r_valid +3 (plus wait states); unmapped address -> r_valid +1.
// Backpres: one transaction in flight; data_gnt_o is low outside IDLE; APB_TIMEOUT_EN bounds ACCESS wait states.
module l2_per_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = DATA_WIDTH/8,
  parameter int AUX_WIDTH      = 4,
  parameter int N_PERIPHS      = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            data_req_i,
  input  logic [ADDR_WIDTH-1:0]           data_add_i,
  input  logic                            data_wen_i,
  input  logic [DATA_WIDTH-1:0]           data_wdata_i,
  input  logic [BE_WIDTH-1:0]             data_be_i,
  input  logic [AUX_WIDTH-1:0]            data_aux_i,
  output logic                            data_gnt_o,
  output logic                            data_r_valid_o,
  output logic [DATA_WIDTH-1:0]           data_r_rdata_o,
  output logic                            data_r_opc_o,
  output logic [AUX_WIDTH-1:0]            data_r_aux_o,
  input  logic [N_PERIPHS*ADDR_WIDTH-1:0] PER_START_ADDR,
  input  logic [N_PERIPHS*ADDR_WIDTH-1:0] PER_END_ADDR,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [DATA_WIDTH-1:0]           pwdata_o,
  output logic                            pwrite_o,
  output logic [BE_WIDTH-1:0]             pstrb_o,
  output logic [N_PERIPHS-1:0]            psel_o,
  output logic                            penable_o,
  input  logic [N_PERIPHS*DATA_WIDTH-1:0] prdata_i,
  input  logic [N_PERIPHS-1:0]            pready_i,
  input  logic [N_PERIPHS-1:0]            pslverr_i
);

  localparam int IDX_W = (N_PERIPHS > 1) ? $clog2(N_PERIPHS) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] ACCESS = 3'd2;
  localparam logic [2:0] RESP   = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  // Error signature returned for unmapped addresses and timeouts.
  localparam logic [31:0]           ERR_WORD32 = 32'hBADACCE5;
  localparam logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(ERR_WORD32);

  logic [2:0]            r_cs;
  logic                  r_ready;
  logic                  r_wen;
  logic [IDX_W-1:0]      r_idx;
  logic [AUX_WIDTH-1:0]  r_aux_lat;

  logic [N_PERIPHS-1:0]  r_psel;
  logic                  r_penable;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_pwrite;
  logic [BE_WIDTH-1:0]   r_pstrb;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_opc;
  logic [AUX_WIDTH-1:0]  r_aux;

  logic                  w_gnt;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_pready;
  logic                  w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_tmo;
  assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // The wait-state limit only matters when the timeout is compiled in.
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  assign w_gnt      = data_req_i & r_ready & (r_cs == IDLE);
  assign data_gnt_o = w_gnt;

  // Selected slave's response lines; r_idx is stable for the whole transfer.
  assign w_pready  = pready_i[r_idx];
  assign w_pslverr = pslverr_i[r_idx];
  assign w_prdata  = prdata_i[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Address decode: scan high to low so the lowest matching region wins on overlap.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = N_PERIPHS-1; k >= 0; k--) begin
      if ((data_add_i >= PER_START_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (data_add_i <  PER_END_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(k);
      end
    end
  end

  // Transfer FSM; APB and response outputs are registered and set on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs      <= IDLE;
      r_ready   <= 1'b0;
      r_wen     <= 1'b0;
      r_idx     <= '0;
      r_aux_lat <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= '0;
      r_valid   <= 1'b0;
      r_rdata   <= '0;
      r_opc     <= 1'b0;
      r_aux     <= '0;
`ifdef APB_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      case (r_cs)
        IDLE: begin
          if (w_gnt) begin
            r_wen     <= data_wen_i;
            r_idx     <= w_hit_idx;
            r_aux_lat <= data_aux_i;
            if (w_hit) begin
              r_cs      <= SETUP;
              r_psel    <= N_PERIPHS'(1) << w_hit_idx;
              r_penable <= 1'b0;
              r_paddr   <= data_add_i;
              r_pwdata  <= data_wdata_i;
              r_pwrite  <= ~data_wen_i;
              r_pstrb   <= data_wen_i ? '0 : data_be_i;
            end else begin
              // No slave owns the address: answer directly, APB stays idle.
              r_cs    <= ERR;
              r_valid <= 1'b1;
              r_rdata <= ERR_DATA;
              r_opc   <= 1'b1;
              r_aux   <= data_aux_i;
            end
          end
        end
        SETUP: begin
          r_cs      <= ACCESS;
          r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (w_pready) begin
            r_cs      <= RESP;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_valid   <= 1'b1;
            r_rdata   <= r_wen ? w_prdata : '0;
            r_opc     <= w_pslverr;
            r_aux     <= r_aux_lat;
          end
`ifdef APB_TIMEOUT_EN
          else if (w_tmo) begin
            r_cs      <= RESP;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_valid   <= 1'b1;
            r_rdata   <= ERR_DATA;
            r_opc     <= 1'b1;
            r_aux     <= r_aux_lat;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        RESP:    r_cs <= IDLE;
        ERR:     r_cs <= IDLE;
        default: r_cs <= IDLE;
      endcase
    end
  end

  assign psel_o         = r_psel;
  assign penable_o      = r_penable;
  assign paddr_o        = r_paddr;
  assign pwdata_o       = r_pwdata;
  assign pwrite_o       = r_pwrite;
  assign pstrb_o        = r_pstrb;
  assign data_r_valid_o = r_valid;
  assign data_r_rdata_o = r_rdata;
  assign data_r_opc_o   = r_opc;
  assign data_r_aux_o   = r_aux;

endmodule

// File: tb/tb_l2_per_apb_bridge.sv
// Directed bench for l2_per_apb_bridge: reads, waited write, unmapped, slave error,
// back-to-back hold-off, async reset mid-transfer and (with APB_TIMEOUT_EN) timeout.
module tb_l2_per_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic [31:0] data_add_i;
  logic        data_wen_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_be_i;
  logic [3:0]  data_aux_i;
  logic        data_gnt_o;
  logic        data_r_valid_o;
  logic [31:0] data_r_rdata_o;
  logic        data_r_opc_o;
  logic [3:0]  data_r_aux_o;
  logic [63:0] per_start;
  logic [63:0] per_end;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic [3:0]  pstrb_o;
  logic [1:0]  psel_o;
  logic        penable_o;
  logic [63:0] prdata_i;
  logic [1:0]  pready_i;
  logic [1:0]  pslverr_i;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  l2_per_apb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .AUX_WIDTH(4),
    .N_PERIPHS(2), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_aux_i(data_aux_i),
    .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
    .data_r_aux_o(data_r_aux_o),
    .PER_START_ADDR(per_start), .PER_END_ADDR(per_end),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .pstrb_o(pstrb_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Region 0 = [1A10_2000,1A10_3000), region 1 = [1A10_0000,1A10_1000)
    per_start    = {32'h1A10_0000, 32'h1A10_2000};
    per_end      = {32'h1A10_1000, 32'h1A10_3000};
    rst_n        = 1'b0;
    data_req_i   = 1'b0;
    data_add_i   = '0;
    data_wen_i   = 1'b1;
    data_wdata_i = '0;
    data_be_i    = '0;
    data_aux_i   = '0;
    prdata_i     = {32'h1111_2222, 32'h3333_4444};
    pready_i     = 2'b11;
    pslverr_i    = 2'b00;

    // ---- reset state
    #1;
    chk("rst_psel", psel_o, 2'b00);
    chk("rst_penable", penable_o, 1'b0);
    chk("rst_rvalid", data_r_valid_o, 1'b0);
    chk("rst_paddr", paddr_o, 32'h0);
    data_req_i = 1'b1;
    #1;
    chk("rst_gnt", data_gnt_o, 1'b0);
    data_req_i = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    data_req_i = 1'b1;
    #1;
    chk("gnt_before_ready", data_gnt_o, 1'b0);
    data_req_i = 1'b0;
    tick;

    // ---- read region 1, pready already high
    data_req_i = 1'b1; data_add_i = 32'h1A10_0004; data_wen_i = 1'b1; data_aux_i = 4'h5;
    #1;
    chk("rd_gnt", data_gnt_o, 1'b1);
    tick;
    data_req_i = 1'b0; data_add_i = 32'h0; data_aux_i = 4'h0;
    chk("rd_setup_psel", psel_o, 2'b10);
    chk("rd_setup_penable", penable_o, 1'b0);
    chk("rd_setup_paddr", paddr_o, 32'h1A10_0004);
    chk("rd_setup_pwrite", pwrite_o, 1'b0);
    chk("rd_setup_pstrb", pstrb_o, 4'h0);
    tick;
    chk("rd_access_psel", psel_o, 2'b10);
    chk("rd_access_penable", penable_o, 1'b1);
    chk("rd_access_rvalid", data_r_valid_o, 1'b0);
    tick;
    chk("rd_resp_rvalid", data_r_valid_o, 1'b1);
    chk("rd_resp_rdata", data_r_rdata_o, 32'h1111_2222);
    chk("rd_resp_opc", data_r_opc_o, 1'b0);
    chk("rd_resp_aux", data_r_aux_o, 4'h5);
    chk("rd_resp_psel", psel_o, 2'b00);
    chk("rd_resp_penable", penable_o, 1'b0);
    tick;
    chk("rd_rvalid_drop", data_r_valid_o, 1'b0);

    // ---- write slave 0 with 3 wait states
    pready_i = 2'b10;
    data_req_i = 1'b1; data_add_i = 32'h1A10_2010; data_wen_i = 1'b0;
    data_wdata_i = 32'hDEAD_BEEF; data_be_i = 4'b0011; data_aux_i = 4'h3;
    #1;
    chk("wr_gnt", data_gnt_o, 1'b1);
    tick;
    data_req_i = 1'b0; data_wdata_i = 32'h0; data_be_i = 4'h0; data_add_i = 32'h0;
    chk("wr_pwrite", pwrite_o, 1'b1);
    chk("wr_pstrb", pstrb_o, 4'b0011);
    chk("wr_paddr", paddr_o, 32'h1A10_2010);
    for (int i = 0; i < 5; i++) begin
      chk("wr_pwdata_hold", pwdata_o, 32'hDEAD_BEEF);
      chk("wr_psel_hold", psel_o, 2'b01);
      chk("wr_penable", penable_o, (i == 0) ? 1'b0 : 1'b1);
      chk("wr_no_early_rvalid", data_r_valid_o, 1'b0);
      if (i == 4) pready_i = 2'b11;
      tick;
    end
    chk("wr_resp_rvalid", data_r_valid_o, 1'b1);
    chk("wr_resp_opc", data_r_opc_o, 1'b0);
    chk("wr_resp_rdata", data_r_rdata_o, 32'h0);
    chk("wr_resp_aux", data_r_aux_o, 4'h3);
    chk("wr_resp_psel", psel_o, 2'b00);
    tick;
    chk("wr_single_rvalid", data_r_valid_o, 1'b0);

    // ---- unmapped address
    data_req_i = 1'b1; data_add_i = 32'h0000_0010; data_wen_i = 1'b1; data_aux_i = 4'hA;
    #1;
    chk("um_gnt", data_gnt_o, 1'b1);
    tick;
    data_req_i = 1'b0;
    chk("um_rvalid", data_r_valid_o, 1'b1);
    chk("um_rdata", data_r_rdata_o, 32'hBADACCE5);
    chk("um_opc", data_r_opc_o, 1'b1);
    chk("um_aux", data_r_aux_o, 4'hA);
    chk("um_psel", psel_o, 2'b00);
    tick;
    chk("um_rvalid_drop", data_r_valid_o, 1'b0);
    chk("um_psel_after", psel_o, 2'b00);

    // ---- end address is exclusive
    data_req_i = 1'b1; data_add_i = 32'h1A10_1000; data_aux_i = 4'h1;
    tick;
    data_req_i = 1'b0;
    chk("end_excl_rvalid", data_r_valid_o, 1'b1);
    chk("end_excl_opc", data_r_opc_o, 1'b1);
    chk("end_excl_psel", psel_o, 2'b00);
    tick;

    // ---- slave error plus back-to-back hold-off
    pslverr_i = 2'b01; prdata_i[31:0] = 32'h55AA_55AA;
    data_req_i = 1'b1; data_add_i = 32'h1A10_2020; data_wen_i = 1'b1; data_aux_i = 4'h6;
    #1;
    chk("se_gnt", data_gnt_o, 1'b1);
    tick;
    data_add_i = 32'h1A10_0008; data_aux_i = 4'h7;
    #1;
    chk("b2b_gnt_setup", data_gnt_o, 1'b0);
    tick;
    chk("b2b_gnt_access", data_gnt_o, 1'b0);
    tick;
    chk("se_rvalid", data_r_valid_o, 1'b1);
    chk("se_opc", data_r_opc_o, 1'b1);
    chk("se_aux", data_r_aux_o, 4'h6);
    chk("se_rdata", data_r_rdata_o, 32'h55AA_55AA);
    chk("b2b_gnt_resp", data_gnt_o, 1'b0);
    pslverr_i = 2'b00;
    tick;
    chk("b2b_rvalid_drop", data_r_valid_o, 1'b0);
    chk("b2b_gnt_idle", data_gnt_o, 1'b1);
    tick;
    data_req_i = 1'b0;
    chk("b2b_psel", psel_o, 2'b10);
    tick; tick;
    chk("b2b_rvalid", data_r_valid_o, 1'b1);
    chk("b2b_opc", data_r_opc_o, 1'b0);
    chk("b2b_aux", data_r_aux_o, 4'h7);
    chk("b2b_rdata", data_r_rdata_o, 32'h1111_2222);
    tick;

    // ---- async reset during ACCESS
    pready_i = 2'b00;
    data_req_i = 1'b1; data_add_i = 32'h1A10_2000; data_wen_i = 1'b1; data_aux_i = 4'h2;
    tick;
    data_req_i = 1'b0;
    tick;
    chk("ar_access_penable", penable_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_psel_async", psel_o, 2'b00);
    chk("ar_penable_async", penable_o, 1'b0);
    pready_i = 2'b11;
    tick;
    chk("ar_no_rvalid", data_r_valid_o, 1'b0);
    tick;
    rst_n = 1'b1;
    data_req_i = 1'b1; data_add_i = 32'h1A10_2004; data_aux_i = 4'h9;
    prdata_i[31:0] = 32'h0BAD_F00D;
    #1;
    chk("ar_gnt_first_cycle", data_gnt_o, 1'b0);
    chk("ar_no_rvalid_release", data_r_valid_o, 1'b0);
    tick;
    chk("ar_gnt_after", data_gnt_o, 1'b1);
    tick;
    data_req_i = 1'b0;
    chk("ar_rd_psel", psel_o, 2'b01);
    tick; tick;
    chk("ar_rd_rvalid", data_r_valid_o, 1'b1);
    chk("ar_rd_rdata", data_r_rdata_o, 32'h0BAD_F00D);
    chk("ar_rd_aux", data_r_aux_o, 4'h9);
    tick;

`ifdef APB_TIMEOUT_EN
    // ---- timeout after 4 ACCESS cycles with pready low
    pready_i = 2'b00;
    data_req_i = 1'b1; data_add_i = 32'h1A10_2008; data_wen_i = 1'b1; data_aux_i = 4'hC;
    tick;
    data_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("to_psel_held", psel_o, 2'b01);
      chk("to_penable_held", penable_o, 1'b1);
    end
    tick;
    chk("to_psel_drop", psel_o, 2'b00);
    chk("to_rvalid", data_r_valid_o, 1'b1);
    chk("to_opc", data_r_opc_o, 1'b1);
    chk("to_rdata", data_r_rdata_o, 32'hBADACCE5);
    chk("to_aux", data_r_aux_o, 4'hC);
    pready_i = 2'b11;
    tick;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/l2_per_apb_bridge.md
Name: l2_per_apb_bridge

Overview:
Downstream consumer of the L2 demux peripheral port (PER req/gnt plus r_valid/r_opc/r_aux response channel). Converts each granted single-beat request into an APB transfer on one of N_PERIPHS slaves, selected by address range. Returns exactly one response per grant: read data or write acknowledge, pslverr mapped to r_opc, and aux echoed. Unmapped addresses get an error response without any APB activity.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable / pstrb width
AUX_WIDTH, 4, sideband echoed on the response
N_PERIPHS, 2, number of APB slaves / address regions
TIMEOUT_CYCLES, 255, wait-state limit; used only with APB_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
data_req_i  in  1  request from demux PER port
data_add_i  in  ADDR_WIDTH  request address
data_wen_i  in  1  1 = read, 0 = write
data_wdata_i  in  DATA_WIDTH  write data
data_be_i  in  BE_WIDTH  byte enables
data_aux_i  in  AUX_WIDTH  sideband
data_gnt_o  out  1  request accepted
data_r_valid_o  out  1  response valid, one-cycle pulse
data_r_rdata_o  out  DATA_WIDTH  response data
data_r_opc_o  out  1  response error
data_r_aux_o  out  AUX_WIDTH  echoed aux
PER_START_ADDR  in  N_PERIPHS*ADDR_WIDTH  region start, inclusive
PER_END_ADDR  in  N_PERIPHS*ADDR_WIDTH  region end, exclusive
paddr_o  out  ADDR_WIDTH  APB address
pwdata_o  out  DATA_WIDTH  APB write data
pwrite_o  out  1  APB write
pstrb_o  out  BE_WIDTH  APB strobes
psel_o  out  N_PERIPHS  one-hot slave select
penable_o  out  1  APB enable
prdata_i  in  N_PERIPHS*DATA_WIDTH  per-slave read data
pready_i  in  N_PERIPHS  per-slave ready
pslverr_i  in  N_PERIPHS  per-slave error

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset state is FSM IDLE, and the ready flop and all registered outputs (psel, penable, paddr, pwdata, pwrite, pstrb, r_valid, r_rdata, r_opc, r_aux) are 0. data_gnt_o = data_req_i & ready & (CS==IDLE), so it is 0 in reset. ready sets 1 on the first clock after reset deasserts.
- Decode: a region k is hit when START[k] <= addr < END[k]. If regions overlap, the lowest k wins. No hit means error.
- FSM states: IDLE, SETUP, ACCESS, RESP, ERR.
- IDLE, on req&gnt: latch addr, wdata, be, aux, wen and the hit index. Go to SETUP on a hit, otherwise go to ERR.
- SETUP: psel_o[k]=1, penable_o=0, pwrite_o=~wen, pstrb_o=be on writes and 0 on reads. Next state is ACCESS.
- ACCESS: psel_o[k]=1 and penable_o=1; hold while pready_i[k]=0. When pready_i[k]=1: capture prdata_i[k] (for writes, capture 0) and pslverr_i[k], drop psel and penable on the next edge, and go to RESP.
- RESP: r_valid=1 for one cycle with captured rdata, opc=pslverr, and latched aux. Next state is IDLE.
- ERR: r_valid=1 for one cycle, rdata=32'hBAD_ACCE5 (zero-extended or truncated to DATA_WIDTH), opc=1, aux latched. Next state is IDLE.
- Outstanding: one transaction at a time. gnt is 0 in every state except IDLE. A new request is granted at the earliest in the cycle r_valid drops.
- Latency (grant at edge T, pready already high): SETUP T+1, ACCESS T+2, r_valid T+3. Error: r_valid at T+1.
- Writes always produce r_valid, so the demux ON_PER state can exit.
- APB address, data and control hold stable from SETUP through the completing ACCESS cycle. Request inputs may change after the grant.
- Reset asserted mid-transfer: psel and penable drop immediately (asynchronously), no response is emitted, and the FSM returns to IDLE.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: a counter clears on SETUP and increments each ACCESS cycle with pready_i[k]=0. When it reaches TIMEOUT_CYCLES, psel/penable drop and the FSM goes to RESP with opc=1 and rdata=BAD_ACCE5. If pready and the limit coincide, pready wins and the response is normal.
- Undefined: no counter, and ACCESS waits indefinitely.

Test Plan:
- Read, region 1 = [0x1A10_0000, 0x1A10_1000), addr 0x1A10_0004, aux 0x5, pready already high -> psel_o=2'b10 at T+1, penable at T+2, r_valid at T+3 with rdata=prdata_i[1], opc 0, aux 0x5.
- Write 0xDEAD_BEEF, be 4'b0011, slave 0 with 3 wait states -> pwrite 1, pstrb 0011, pwdata stable 5 cycles, single r_valid, opc 0.
- Unmapped addr 0x0000_0010 -> gnt 1, no psel ever, r_valid at T+1 with rdata 0xBAD_ACCE5, opc 1.
- pslverr_i[0]=1 with pready -> r_valid with opc 1 and aux echoed; a back-to-back request is held off (gnt 0) until r_valid drops, then granted.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS cycles, r_valid with opc 1, rdata 0xBAD_ACCE5.
- rst_n pulsed low during ACCESS -> psel/penable 0 immediately, no r_valid, gnt 0 in the first cycle after release, normal read completes afterwards.
